// File: rtl/bch_correct_buffer_pkg.sv
// Shared types and elaboration helpers for the BCH correction buffer.
package bch_correct_buffer_pkg;

    typedef enum logic {
        RD_IDLE    = 1'b0,
        RD_CORRECT = 1'b1
    } rd_state_e;

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int unsigned index_width(input int unsigned count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/bch_correct_buffer_if.sv
// Data-in, error-in and corrected-out signals of one decoder channel's correction buffer.
interface bch_correct_buffer_if #(
    parameter int unsigned BITS  = 1,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_first;
    logic [BITS-1:0]  in_data;
    logic             err_first;
    logic [BITS-1:0]  err;
    logic             out_valid;
    logic             out_first;
    logic             out_last;
    logic [BITS-1:0]  out_data;
    logic             overflow;
    logic             underrun;
    logic [CNT_W-1:0] words;

    modport master (
        output in_valid, in_first, in_data, err_first, err,
        input  out_valid, out_first, out_last, out_data, overflow, underrun, words
    );

    modport slave (
        input  in_valid, in_first, in_data, err_first, err,
        output out_valid, out_first, out_last, out_data, overflow, underrun, words
    );

endinterface

// File: rtl/bch_correct_buffer_ram.sv
// Simple dual-port codeword store: one write port, one registered read port.
module bch_buffer_ram #(
    parameter int unsigned WIDTH   = 1,
    parameter int unsigned ENTRIES = 20,
    parameter int unsigned ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [ENTRIES];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/bch_correct_buffer.sv
// Buffers received codeword data beats and replays them XORed with the decoder's
// error stream, one codeword per correction pass, in arrival order.
module bch_correct_buffer
    import bch_correct_buffer_pkg::*;
#(
    parameter int unsigned DATA_BITS = 5,
    parameter int unsigned BITS      = 1,
    parameter int unsigned DEPTH     = 4
) (
    input logic                clk,
    input logic                rst,
    bch_correct_buffer_if.slave bus
);

    localparam int unsigned BEATS   = ceil_div(DATA_BITS, BITS);
    localparam int unsigned BEAT_W  = index_width(BEATS);
    localparam int unsigned SLOT_W  = index_width(DEPTH);
    localparam int unsigned ENTRIES = DEPTH * BEATS;
    localparam int unsigned ADDR_W  = index_width(ENTRIES);
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  FULL      = CNT_W'(DEPTH);

    function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] slot);
        return (slot == LAST_SLOT) ? '0 : slot + SLOT_W'(1);
    endfunction

    function automatic logic [ADDR_W-1:0] beat_addr(input logic [SLOT_W-1:0] slot,
                                                    input logic [BEAT_W-1:0] beat);
        return ADDR_W'(slot) * ADDR_W'(BEATS) + ADDR_W'(beat);
    endfunction

    // Write side
    logic [SLOT_W-1:0] wr_slot_q, wr_slot_d;
    logic [BEAT_W-1:0] wr_beat_q, wr_beat_d;
    logic              wr_active_q, wr_active_d;
    logic [BEAT_W-1:0] wr_idx;
    logic              wr_done;

    // Read side
    rd_state_e         state_q, state_d;
    logic [SLOT_W-1:0] rd_slot_q, rd_slot_d;
    logic [BEAT_W-1:0] rd_beat_q, rd_beat_d;
    logic              rd_done;

    // Shared status and registered outputs
    logic [CNT_W-1:0]  words_q, words_d;
    logic              overflow_q, overflow_d;
    logic              underrun_q, underrun_d;
    logic              out_valid_q, out_valid_d;
    logic              out_first_q, out_first_d;
    logic              out_last_q, out_last_d;
    logic [BITS-1:0]   out_data_q, out_data_d;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [ADDR_W-1:0] ram_raddr;
    logic [BITS-1:0]   ram_rdata;

    always_comb begin
        wr_slot_d   = wr_slot_q;
        wr_beat_d   = wr_beat_q;
        wr_active_d = wr_active_q;
        overflow_d  = overflow_q;
        wr_idx      = wr_beat_q;
        wr_done     = 1'b0;
        ram_we      = 1'b0;

        if (bus.in_valid && bus.in_first) begin
            if (words_q == FULL) begin
                // Dropping the header leaves the rest of the word unanchored, so it is ignored.
                wr_active_d = 1'b0;
                overflow_d  = 1'b1;
            end else begin
                wr_idx = '0;
                ram_we = 1'b1;
            end
        end else if (bus.in_valid && wr_active_q) begin
            ram_we = 1'b1;
        end

        if (ram_we) begin
            if (wr_idx == LAST_BEAT) begin
                wr_done     = 1'b1;
                wr_active_d = 1'b0;
                wr_beat_d   = '0;
                wr_slot_d   = next_slot(wr_slot_q);
            end else begin
                wr_active_d = 1'b1;
                wr_beat_d   = wr_idx + BEAT_W'(1);
            end
        end
        ram_waddr = beat_addr(wr_slot_q, wr_idx);
    end

    always_comb begin
        state_d    = state_q;
        rd_slot_d  = rd_slot_q;
        rd_beat_d  = rd_beat_q;
        underrun_d = underrun_q;
        rd_done    = 1'b0;

        case (state_q)
            RD_IDLE: begin
                if (bus.err_first) begin
                    if (words_q != '0) begin
                        state_d   = RD_CORRECT;
                        rd_beat_d = '0;
                    end else begin
                        underrun_d = 1'b1;
                    end
                end
            end
            RD_CORRECT: begin
                if (rd_beat_q == LAST_BEAT) begin
                    rd_done   = 1'b1;
                    rd_slot_d = next_slot(rd_slot_q);
                    rd_beat_d = '0;
                    // The word being finished still counts in words_q, so a follow-on pass needs two.
                    if (bus.err_first && (words_q > CNT_W'(1))) begin
                        state_d = RD_CORRECT;
                    end else begin
                        state_d = RD_IDLE;
                        if (bus.err_first) begin
                            underrun_d = 1'b1;
                        end
                    end
                end else begin
                    rd_beat_d = rd_beat_q + BEAT_W'(1);
                    if (bus.err_first) begin
                        underrun_d = 1'b1;
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase

        // Address follows the next-state pointers so the registered read lands on time.
        ram_raddr = beat_addr(rd_slot_d, rd_beat_d);

        out_valid_d = (state_q == RD_CORRECT);
        out_first_d = (state_q == RD_CORRECT) && (rd_beat_q == '0);
        out_last_d  = rd_done;
        out_data_d  = (state_q == RD_CORRECT) ? (ram_rdata ^ bus.err) : '0;
    end

    always_comb begin
        words_d = words_q;
        case ({wr_done, rd_done})
            2'b10:   words_d = words_q + CNT_W'(1);
            2'b01:   words_d = words_q - CNT_W'(1);
            default: words_d = words_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_slot_q   <= '0;
            wr_beat_q   <= '0;
            wr_active_q <= 1'b0;
            state_q     <= RD_IDLE;
            rd_slot_q   <= '0;
            rd_beat_q   <= '0;
            words_q     <= '0;
            overflow_q  <= 1'b0;
            underrun_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_slot_q   <= wr_slot_d;
            wr_beat_q   <= wr_beat_d;
            wr_active_q <= wr_active_d;
            state_q     <= state_d;
            rd_slot_q   <= rd_slot_d;
            rd_beat_q   <= rd_beat_d;
            words_q     <= words_d;
            overflow_q  <= overflow_d;
            underrun_q  <= underrun_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    bch_buffer_ram #(
        .WIDTH   (BITS),
        .ENTRIES (ENTRIES),
        .ADDR_W  (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (bus.in_data),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign bus.out_valid = out_valid_q;
    assign bus.out_first = out_first_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = out_data_q;
    assign bus.overflow  = overflow_q;
    assign bus.underrun  = underrun_q;
    assign bus.words     = words_q;

endmodule

// File: tb/tb_bch_correct_buffer.sv
// Randomized self-checking bench: a queue-based codeword model predicts every corrected word.
module tb_bch_correct_buffer;

    localparam int unsigned DATA_BITS = 5;
    localparam int unsigned BITS      = 1;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned BEATS     = 5;

    typedef logic [DATA_BITS-1:0] word_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bch_correct_buffer_if #(.BITS(BITS), .DEPTH(DEPTH)) bus();

    bch_correct_buffer #(
        .DATA_BITS (DATA_BITS),
        .BITS      (BITS),
        .DEPTH     (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: complete words awaiting a pass, expected corrected words, pass start times.
    word_t       stored[$];
    word_t       exp_words[$];
    int unsigned exp_first_cyc[$];
    int          mcount;
    int          w_beat;
    word_t       w_word;
    bit          w_drop;
    int          r_beat;
    word_t       r_err;
    bit          exp_ovf;
    bit          exp_unr;

    // Output monitor
    bit          m_in_word = 1'b0;
    int          m_beat    = 0;
    word_t       m_asm, m_last_word;
    int unsigned m_words_out = 0;
    int unsigned m_run = 0, m_last_run = 0;

    always @(negedge clk) begin
        if (rst) begin
            m_in_word = 1'b0;
            m_run     = 0;
        end else if (bus.out_valid) begin
            m_run++;
            check("first_flag", bus.out_first, !m_in_word);
            if (!m_in_word) begin
                m_in_word = 1'b1;
                m_beat    = 0;
                m_asm     = '0;
                if (exp_first_cyc.size() == 0) check("unexpected_pass", 1, 0);
                else check("first_latency", cyc, exp_first_cyc.pop_front());
            end
            m_asm[m_beat] = bus.out_data[0];
            check("last_flag", bus.out_last, m_beat == BEATS - 1);
            if (m_beat == BEATS - 1) begin
                m_in_word   = 1'b0;
                m_words_out++;
                m_last_word = m_asm;
                if (exp_words.size() == 0) check("unexpected_word", 1, 0);
                else check("word", m_asm, exp_words.pop_front());
            end else begin
                m_beat++;
            end
        end else begin
            if (m_in_word) begin
                check("word_gap", 1, 0);
                m_in_word = 1'b0;
            end
            if (m_run != 0) begin
                m_last_run = m_run;
                m_run      = 0;
            end
        end
    end

    // One clock of stimulus: optional word start, write gap/stray beat, err_first; model advances.
    task automatic tick(input bit wstart, input bit wgap, input bit rstart,
                        input word_t wval, input word_t eval);
        bit complete, final_b, accept;
        complete = 1'b0;
        final_b  = 1'b0;
        accept   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.in_data   = '0;
        bus.err_first = 1'b0;
        bus.err       = BITS'($urandom);
        if (wstart) begin
            bus.in_valid = 1'b1;
            bus.in_first = 1'b1;
            bus.in_data  = wval[0];
            w_word       = wval;
            w_drop       = (mcount == DEPTH);
            if (w_drop) exp_ovf = 1'b1;
            w_beat       = 1;
        end else if (w_beat > 0 && !wgap) begin
            bus.in_valid = 1'b1;
            bus.in_data  = w_word[w_beat];
            if (w_beat == BEATS - 1) begin
                complete = !w_drop;
                w_beat   = -1;
            end else begin
                w_beat++;
            end
        end else if (w_beat < 0 && wgap) begin
            bus.in_valid = 1'b1;
            bus.in_data  = BITS'($urandom);
        end
        if (r_beat >= 0) begin
            bus.err = r_err[r_beat];
            final_b = (r_beat == BEATS - 1);
        end
        if (rstart) begin
            bus.err_first = 1'b1;
            if ((r_beat < 0 && mcount > 0) || (final_b && mcount > 1)) accept = 1'b1;
            else exp_unr = 1'b1;
        end
        if (accept) begin
            exp_words.push_back(stored.pop_front() ^ eval);
            exp_first_cyc.push_back(cyc + 2);
        end
        @(posedge clk);
        #1;
        if (complete) begin
            stored.push_back(w_word);
            mcount++;
        end
        if (final_b) mcount--;
        if (accept) begin
            r_beat = 0;
            r_err  = eval;
        end else if (final_b) begin
            r_beat = -1;
        end else if (r_beat >= 0) begin
            r_beat++;
        end
        check("words", bus.words, mcount);
        check("overflow", bus.overflow, exp_ovf);
        check("underrun", bus.underrun, exp_unr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic write_word(input word_t w);
        tick(1'b1, 1'b0, 1'b0, w, '0);
        for (int i = 1; i < BEATS; i++) tick(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // n passes chained back-to-back via err_first on each final beat.
    task automatic run_passes(input int n, input word_t first_err);
        int left;
        bit go;
        left = n - 1;
        tick(1'b0, 1'b0, 1'b1, '0, first_err);
        for (int g = 0; g < n * BEATS + 4 && r_beat >= 0; g++) begin
            go = (r_beat == BEATS - 1) && (left > 0);
            tick(1'b0, 1'b0, go, '0, word_t'($urandom));
            if (go) left--;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.in_data   = '0;
        bus.err_first = 1'b0;
        bus.err       = '0;
        @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_first", bus.out_first, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_underrun", bus.underrun, 0);
        check("rst_words", bus.words, 0);
        stored.delete();
        exp_words.delete();
        exp_first_cyc.delete();
        mcount  = 0;
        w_beat  = -1;
        w_drop  = 1'b0;
        r_beat  = -1;
        exp_ovf = 1'b0;
        exp_unr = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned start_out;
        int          guard;
        word_t       wv, ev;
        bit          ws, wg, rs;

        do_reset();

        // Directed: beats 1,0,1,1,0 corrected by error on beat 2 -> 1,0,0,1,0.
        write_word(5'b01101);
        idle(1);
        run_passes(1, 5'b00100);
        idle(2);
        check("basic_word", m_last_word, 5'b01001);
        check("basic_words", bus.words, 0);

        // err_first with nothing stored.
        tick(1'b0, 1'b0, 1'b1, '0, '0);
        idle(4);
        check("underrun_set", bus.underrun, 1);
        check("underrun_no_output", m_words_out, 1);
        do_reset();

        // Fill, overflow on a fifth word, then drain four passes back-to-back.
        for (int i = 0; i < DEPTH; i++) begin
            write_word(word_t'($urandom));
            idle(1);
        end
        check("full_words", bus.words, DEPTH);
        write_word(word_t'($urandom));
        idle(1);
        check("ovf_set", bus.overflow, 1);
        check("ovf_words", bus.words, DEPTH);
        run_passes(DEPTH, word_t'($urandom));
        idle(2);
        check("b2b_run", m_last_run, DEPTH * BEATS);
        check("ovf_drained", exp_words.size(), 0);
        check("ovf_empty", bus.words, 0);
        do_reset();

        // A word completes on the same edge a pass ends.
        write_word(word_t'($urandom));
        idle(1);
        tick(1'b0, 1'b0, 1'b1, '0, word_t'($urandom));
        write_word(word_t'($urandom));
        check("collide_words", bus.words, 1);
        idle(1);
        run_passes(1, word_t'($urandom));
        idle(2);
        check("collide_drained", exp_words.size(), 0);

        // Random concurrent traffic, no protocol errors; wraps the slot ring many times.
        start_out = m_words_out;
        for (int i = 0; i < 800; i++) begin
            ws = ((w_beat < 0) && (mcount < DEPTH) && ($urandom_range(99) < 35)) ||
                 ((w_beat > 0) && ($urandom_range(99) < 3));
            wg = ($urandom_range(99) < 20);
            rs = ((r_beat < 0) && (mcount > 0) && ($urandom_range(99) < 30)) ||
                 ((r_beat == BEATS - 1) && (mcount > 1) && ($urandom_range(99) < 70));
            wv = word_t'($urandom);
            ev = word_t'($urandom);
            tick(ws, wg, rs, wv, ev);
        end
        guard = 0;
        while ((w_beat >= 0 || r_beat >= 0 || mcount > 0) && guard < 300) begin
            rs = ((r_beat < 0) && (mcount > 0)) || ((r_beat == BEATS - 1) && (mcount > 1));
            tick(1'b0, 1'b0, rs, '0, word_t'($urandom));
            guard++;
        end
        idle(2);
        check("random_drain_bound", guard < 300, 1);
        check("random_drained", exp_words.size(), 0);
        check("random_wrap", (m_words_out - start_out) >= 9, 1);

        // Reset in the middle of a pass and a write.
        write_word(word_t'($urandom));
        idle(1);
        tick(1'b0, 1'b0, 1'b1, '0, word_t'($urandom));
        tick(1'b1, 1'b0, 1'b0, word_t'($urandom), '0);
        idle(2);
        do_reset();
        wv = word_t'($urandom);
        ev = word_t'($urandom);
        write_word(wv);
        idle(1);
        run_passes(1, ev);
        idle(2);
        check("post_rst_word", m_last_word, wv ^ ev);
        check("post_rst_words", bus.words, 0);
        check("post_rst_drained", exp_words.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
